// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write scheduler.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One write request for the register file port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } sched_state_t;

  // One-hot mask for a register index, used by the pending scoreboard.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_fifo.sv
// Small circular buffer holding long-latency results until they win the write port.
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == (PTR_W+1)'(0));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  // Guard against overflow/underflow even if a caller misbehaves.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else         rd_ptr_d = rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; contents are discarded on reset simply by clearing the pointers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: WB has priority, long-latency results are queued,
// a pending scoreboard feeds decode hazards, and a starvation FSM can freeze the pipeline.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wbValid,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  input  logic            mdValid,
  output logic            mdReady,
  input  logic [4:0]      mdRd,
  input  logic [XLEN-1:0] mdData,
  input  logic            issueValid,
  input  logic [4:0]      issueRd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rdQ,
  output logic            hazardStall,
  output logic            pipelineStall,
  output logic            registerWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] writeData
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  sched_state_t                state_q, state_d;
  logic [CNT_W-1:0]            starve_q, starve_d;
  logic [NUM_REGS-1:0]         pending_q, pending_d;
  logic                        register_write_q, register_write_d;
  logic [4:0]                  rd_q, rd_d;
  logic [XLEN-1:0]             write_data_q, write_data_d;
  logic                        src_md_q, src_md_d;
  logic                        pipeline_stall_q, pipeline_stall_d;

  wb_req_t                     fifo_head;
  wb_req_t                     md_req;
  wb_req_t                     sel_req;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        wb_win, md_accept, md_keep;
  logic                        fifo_pop, fifo_push, bypass;
  logic                        sel_valid, sel_from_md;
  logic [NUM_REGS-1:0]         set_mask, clr_mask;

  assign md_req.rd   = mdRd;
  assign md_req.data = mdData;

  // Ready only reflects occupancy, never the same-cycle pop.
  assign mdReady     = reset && !fifo_full;
  assign hazardStall = pending_q[rs1] | pending_q[rs2] | pending_q[rdQ];

  assign registerWrite = register_write_q;
  assign rd            = rd_q;
  assign writeData     = write_data_q;
  assign pipelineStall = pipeline_stall_q;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (md_req),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Port arbitration: a real WB write wins, then the FIFO head, then a same-cycle bypass.
  always_comb begin
    wb_win      = wbValid && (wbRd != 5'd0);
    md_accept   = mdValid && mdReady;
    md_keep     = md_accept && (mdRd != 5'd0);
    fifo_pop    = 1'b0;
    bypass      = 1'b0;
    sel_valid   = 1'b0;
    sel_from_md = 1'b0;
    sel_req     = '0;
    if (wb_win) begin
      sel_valid    = 1'b1;
      sel_req.rd   = wbRd;
      sel_req.data = wbData;
    end else if (!fifo_empty) begin
      fifo_pop    = 1'b1;
      sel_valid   = 1'b1;
      sel_from_md = 1'b1;
      sel_req     = fifo_head;
    end else if (md_keep) begin
      bypass      = 1'b1;
      sel_valid   = 1'b1;
      sel_from_md = 1'b1;
      sel_req     = md_req;
    end else begin
      sel_valid   = 1'b0;
    end
    // rd==0 results complete the handshake but are never stored.
    fifo_push = md_keep && !bypass;
  end

  // Next write-port values and scoreboard; a bit clears once its result is on the port, set wins.
  always_comb begin
    register_write_d = sel_valid;
    rd_d             = sel_valid ? sel_req.rd : 5'd0;
    write_data_d     = sel_valid ? sel_req.data : {XLEN{1'b0}};
    src_md_d         = sel_valid && sel_from_md;
    clr_mask         = (register_write_q && src_md_q) ? rd_onehot(rd_q) : {NUM_REGS{1'b0}};
    set_mask         = (issueValid && (issueRd != 5'd0)) ? rd_onehot(issueRd) : {NUM_REGS{1'b0}};
    pending_d        = ((pending_q & ~clr_mask) | set_mask) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
  end

  // Starvation FSM next state and starve counter.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      NORMAL: begin
        if (!fifo_empty && wb_win) starve_d = starve_q + CNT_W'(1);
        else                       starve_d = '0;
        if (starve_d == CNT_W'(STARVE_LIMIT)) begin
          state_d  = DRAIN;
          starve_d = '0;
        end else begin
          state_d  = NORMAL;
        end
      end
      DRAIN: begin
        starve_d = '0;
        if (fifo_count == '0) state_d = NORMAL;
        else                  state_d = DRAIN;
      end
      default: begin
        state_d  = NORMAL;
        starve_d = '0;
      end
    endcase
  end

  // FSM output: request a freeze for every cycle spent draining.
  always_comb begin
    pipeline_stall_d = (state_d == DRAIN);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= NORMAL;
    else        state_q <= state_d;
  end

  // Write port, scoreboard and counter registers; reset cancels any selected write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      register_write_q <= 1'b0;
      rd_q             <= 5'd0;
      write_data_q     <= {XLEN{1'b0}};
      src_md_q         <= 1'b0;
      pending_q        <= {NUM_REGS{1'b0}};
      starve_q         <= '0;
      pipeline_stall_q <= 1'b0;
    end else begin
      register_write_q <= register_write_d;
      rd_q             <= rd_d;
      write_data_q     <= write_data_d;
      src_md_q         <= src_md_d;
      pending_q        <= pending_d;
      starve_q         <= starve_d;
      pipeline_stall_q <= pipeline_stall_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus random traffic against a queue model.
module tb_regfile_write_scheduler;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wbValid = 1'b0, mdValid = 1'b0, issueValid = 1'b0;
  logic [4:0]  wbRd = 5'd0, mdRd = 5'd0, issueRd = 5'd0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rdQ = 5'd0;
  logic [31:0] wbData = 32'd0, mdData = 32'd0;
  logic        mdReady, hazardStall, pipelineStall, registerWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;

  always #5 clock = ~clock;

  regfile_write_scheduler #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData),
    .mdValid(mdValid), .mdReady(mdReady), .mdRd(mdRd), .mdData(mdData),
    .issueValid(issueValid), .issueRd(issueRd),
    .rs1(rs1), .rs2(rs2), .rdQ(rdQ),
    .hazardStall(hazardStall), .pipelineStall(pipelineStall),
    .registerWrite(registerWrite), .rd(rd), .writeData(writeData)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: queue of buffered results, pending set, starvation bookkeeping,
  // and the write that must appear on the port after the coming edge.
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  bit          pend[32];
  int          starve = 0;
  bit          drain = 1'b0;
  bit          e_we = 1'b0, e_md = 1'b0, e_stall = 1'b0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input bit iv, input logic [4:0] ir);
    wbValid = wv; wbRd = wr; wbData = wd;
    mdValid = mv; mdRd = mr; mdData = md;
    issueValid = iv; issueRd = ir;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit         accept, wbw, had, byp, n_we, n_md, was_rst;
    logic [4:0] r;
    logic [31:0] d;
    bit         np[32];
    #1;
    chk("mdReady", mdReady, reset && (q_rd.size() < DEPTH));
    chk("hazardStall", hazardStall, pend[rs1] | pend[rs2] | pend[rdQ]);
    was_rst = !reset;
    if (!reset) begin
      q_rd.delete(); q_data.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      starve = 0; drain = 1'b0;
      e_we = 1'b0; e_md = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_stall = 1'b0;
    end else begin
      if (wbValid && pend[wbRd]) begin
        fails++;
        $display("FAIL waw_guard: WB to pending r%0d", wbRd);
      end
      accept = mdValid && (q_rd.size() < DEPTH);
      wbw    = wbValid && (wbRd != 5'd0);
      had    = q_rd.size() > 0;
      np = pend;
      if (e_we && e_md) np[e_rd] = 1'b0;
      if (issueValid && issueRd != 5'd0) np[issueRd] = 1'b1;
      byp = 1'b0; n_we = 1'b1; n_md = 1'b1; r = 5'd0; d = 32'd0;
      if (wbw) begin
        r = wbRd; d = wbData; n_md = 1'b0;
      end else if (had) begin
        r = q_rd.pop_front(); d = q_data.pop_front();
      end else if (accept && mdRd != 5'd0) begin
        r = mdRd; d = mdData; byp = 1'b1;
      end else begin
        n_we = 1'b0; n_md = 1'b0;
      end
      if (accept && mdRd != 5'd0 && !byp) begin
        q_rd.push_back(mdRd); q_data.push_back(mdData);
      end
      if (!drain) begin
        if (had && wbw) starve++;
        else            starve = 0;
        if (starve == LIMIT) begin drain = 1'b1; starve = 0; end
      end else if (!had) begin
        drain = 1'b0;
      end
      pend = np;
      e_we = n_we; e_md = n_md; e_rd = r; e_data = d; e_stall = drain;
    end
    @(posedge clock); #1;
    chk("registerWrite", registerWrite, e_we);
    if (e_we || was_rst) begin
      chk("rd", rd, e_rd);
      chk("writeData", writeData, e_data);
    end
    chk("pipelineStall", pipelineStall, e_stall);
  endtask

  initial begin
    foreach (pend[i]) pend[i] = 1'b0;
    @(posedge clock); #1;

    // 1: reset held 3 cycles while a result is offered
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    rs1 = 5'd9; rs2 = 5'd6; rdQ = 5'd7;
    repeat (3) step();
    chk("t1_registerWrite", registerWrite, 32'd0);
    chk("t1_mdReady", mdReady, 32'd0);
    chk("t1_hazard", hazardStall, 32'd0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    rs1 = 5'd0; rs2 = 5'd0; rdQ = 5'd0;
    step();

    // 2: WB beats the FIFO head
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0); step();
    drive(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t2_rd_wb", rd, 32'd5); chk("t2_data_wb", writeData, 32'hAA);
    chk("t2_model_rd", e_rd, 32'd5);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t2_rd_md", rd, 32'd7); chk("t2_data_md", writeData, 32'hBB);
    chk("t2_model_data", e_data, 32'hBB);

    // 3: scoreboard set, clear after the port write, set-wins collision
    rs1 = 5'd7;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7); step();
    chk("t3_set", hazardStall, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0); step();
    chk("t3_bypass_rd", rd, 32'd7); chk("t3_still_set", hazardStall, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t3_cleared", hazardStall, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7); step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0); step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7); step();
    chk("t3_set_wins", hazardStall, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h79, 1'b0, 5'd0); step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t3_final_clear", hazardStall, 32'd0);
    rs1 = 5'd0;

    // 4: fill the FIFO behind a busy WB, hold the 5th, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 5'd0); step();
    end
    chk("t4_full", mdReady, 32'd0);
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'h104, 1'b0, 5'd0); step();
    chk("t4_held", mdReady, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h104, 1'b0, 5'd0); step();
    chk("t4_pop0", rd, 32'd10); chk("t4_ready_again", mdReady, 32'd1);
    step();
    chk("t4_pop1", rd, 32'd11);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    repeat (3) step();
    chk("t4_last", rd, 32'd14); chk("t4_last_data", writeData, 32'h104);

    // 5: starvation of a single entry triggers DRAIN after exactly LIMIT lost cycles
    drive(1'b1, 5'd1, 32'h5, 1'b1, 5'd20, 32'h20, 1'b0, 5'd0); step();
    drive(1'b1, 5'd2, 32'h6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    repeat (LIMIT - 1) step();
    chk("t5_not_yet", pipelineStall, 32'd0);
    step();
    chk("t5_stall", pipelineStall, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t5_written", rd, 32'd20); chk("t5_stall_held", pipelineStall, 32'd1);
    step();
    chk("t5_released", pipelineStall, 32'd0);

    // 6: x0 traffic
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0); step();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t6_r3", rd, 32'd3); chk("t6_r3_data", writeData, 32'h33);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h44, 1'b1, 5'd0); step();
    chk("t6_x0_nowrite", registerWrite, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    chk("t6_x0_nowrite2", registerWrite, 32'd0);
    chk("t6_x0_pending", hazardStall, 32'd0);

    // Random traffic, alternating light and heavy WB load, with occasional resets
    for (int i = 0; i < 4000; i++) begin
      int wbp;
      wbp = ((i / 400) % 2 == 1) ? 95 : 45;
      reset      = ($urandom_range(0, 299) != 0);
      wbValid    = ($urandom_range(0, 99) < wbp);
      wbRd       = 5'($urandom_range(0, 31));
      if (pend[wbRd]) wbRd = 5'd0;
      wbData     = $urandom;
      mdValid    = ($urandom_range(0, 99) < 40);
      mdRd       = 5'($urandom_range(0, 31));
      mdData     = $urandom;
      issueValid = ($urandom_range(0, 99) < 25);
      issueRd    = 5'($urandom_range(0, 31));
      rs1        = 5'($urandom_range(0, 31));
      rs2        = 5'($urandom_range(0, 31));
      rdQ        = 5'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
